// File: rtl/uarc_pkg.sv
// -----------------------------------------------------------------------------
// uarc_pkg
// Types shared by the UARC receiver and its message FIFO.
//   rx_state_e  : receiver FSM state (IDLE, INCEPT_WAIT, INCEPT_ACK)
//   msg_entry_t : one FIFO entry {data, stream}. The data field is sized for
//                 the widest supported word; narrower builds zero-extend on
//                 write and truncate on read.
// -----------------------------------------------------------------------------
package uarc_pkg;

    localparam int unsigned MAX_WORD_MAG   = 6;
    localparam int unsigned MAX_WORD_WIDTH = 1 << MAX_WORD_MAG;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        INCEPT_WAIT = 2'd1,
        INCEPT_ACK  = 2'd2
    } rx_state_e;

    typedef struct packed {
        logic [MAX_WORD_WIDTH-1:0] data;
        logic                      stream;   // 1 = stream word, 0 = send
    } msg_entry_t;

endpackage

// File: rtl/uarc_msg_fifo.sv
// -----------------------------------------------------------------------------
// uarc_msg_fifo
// Message buffer between the bus side and the consumer. Power-of-two depth,
// wrapping FIFO_MAG-bit pointers, (FIFO_MAG+1)-bit occupancy count. A push is
// taken when not full, or when full and a pop happens in the same cycle.
// flush empties the buffer at the edge and overrides push/pop.
// Ports:
//   clk, reset (sync, active-low), flush
//   push, push_data, push_stream  : write side
//   pop                           : consume head (ignored when empty)
//   head_data, head_stream        : current head entry
//   empty, full                   : status
// -----------------------------------------------------------------------------
module uarc_msg_fifo
    import uarc_pkg::*;
#(
    parameter int WORD_MAG = 5,
    parameter int FIFO_MAG = 2,
    localparam int WORD_WIDTH = 1 << WORD_MAG
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  push,
    input  logic [WORD_WIDTH-1:0] push_data,
    input  logic                  push_stream,
    input  logic                  pop,
    output logic [WORD_WIDTH-1:0] head_data,
    output logic                  head_stream,
    output logic                  empty,
    output logic                  full
);

    localparam int unsigned DEPTH = 1 << FIFO_MAG;

    logic [FIFO_MAG-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_MAG-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_MAG:0]   count_q,  count_d;
    msg_entry_t          mem_q [DEPTH];

    logic do_push;
    logic do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == (FIFO_MAG+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    // NOTE: every signal written in always_comb gets a default first, so no
    // path through the block can leave it unassigned and infer a latch.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (do_push && !do_pop) count_d = count_q + 1'b1;
            if (do_pop && !do_push) count_d = count_q - 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: the storage array has no reset; the count alone decides which
    // entries are valid, so clearing the data would only cost logic.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= '{data: MAX_WORD_WIDTH'(push_data), stream: push_stream};
        end
    end

    assign head_data   = mem_q[rd_ptr_q].data[WORD_WIDTH-1:0];
    assign head_stream = mem_q[rd_ptr_q].stream;

endmodule

// File: rtl/uarc_receiver.sv
// -----------------------------------------------------------------------------
// uarc_receiver
// Bus-side receiver: arbitrates kill > incept > send > stream requests from a
// remote sender, buffers send/stream words in a FIFO for the consumer, runs
// the incept handshake with the core, and issues a one-cycle kill pulse.
// Optional build macro UARC_RECEIVER_ADDR_FILTER_EN adds local_address and
// accepts requests only when the permission-masked self_address matches it.
// Ports:
//   clk, reset (sync, active-low)
//   enable, kill, incept, send, stream         : sender requests
//   kill_ack, incept_ack, send_ack, stream_ack : acknowledges to the sender
//   data, self_permission, self_address,
//   incept_permission, incept_address          : bus payload
//   msg_valid/msg_ready/msg_data/msg_stream    : consumer port
//   incept_req/incept_done/incept_perm_out/incept_addr_out : core incept
//   kill_out                                   : kill pulse to the core
//   local_address (filter build only)
// -----------------------------------------------------------------------------
module uarc_receiver
    import uarc_pkg::*;
#(
    parameter int WORD_MAG = 5,
    parameter int FIFO_MAG = 2,
    localparam int WORD_WIDTH = 1 << WORD_MAG
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  kill,
    input  logic                  incept,
    input  logic                  send,
    input  logic                  stream,
    output logic                  kill_ack,
    output logic                  incept_ack,
    output logic                  send_ack,
    output logic                  stream_ack,
    input  logic [WORD_WIDTH-1:0] data,
    input  logic [WORD_WIDTH-1:0] self_permission,
    input  logic [WORD_WIDTH-1:0] self_address,
    input  logic [WORD_WIDTH-1:0] incept_permission,
    input  logic [WORD_WIDTH-1:0] incept_address,
`ifdef UARC_RECEIVER_ADDR_FILTER_EN
    input  logic [WORD_WIDTH-1:0] local_address,
`endif
    output logic                  msg_valid,
    input  logic                  msg_ready,
    output logic [WORD_WIDTH-1:0] msg_data,
    output logic                  msg_stream,
    output logic                  incept_req,
    input  logic                  incept_done,
    output logic [WORD_WIDTH-1:0] incept_perm_out,
    output logic [WORD_WIDTH-1:0] incept_addr_out,
    output logic                  kill_out
);

    rx_state_e state_q, state_d;

    logic [WORD_WIDTH-1:0] incept_perm_q, incept_perm_d;
    logic [WORD_WIDTH-1:0] incept_addr_q, incept_addr_d;
    logic                  kill_out_q;

    logic addr_match;
    logic req_ok;
    logic is_idle;
    logic kill_acc, incept_acc, send_acc, stream_acc;
    logic fifo_empty, fifo_full, fifo_pop, fifo_room;
    logic [WORD_WIDTH-1:0] head_data;
    logic                  head_stream;

`ifdef UARC_RECEIVER_ADDR_FILTER_EN
    assign addr_match = ((self_address & self_permission) == (local_address & self_permission));
`else
    assign addr_match = 1'b1;
`endif

    // Nothing is accepted while reset is held, so no ack escapes during reset.
    assign req_ok  = reset & enable & addr_match;
    assign is_idle = (state_q == IDLE);

    // A pop in the same cycle frees a slot for a push into a full FIFO.
    assign fifo_pop  = msg_valid & msg_ready;
    assign fifo_room = ~fifo_full | fifo_pop;

    // Fixed priority: each request is masked by every higher one.
    assign kill_acc   = req_ok & kill;
    assign incept_acc = req_ok & ~kill & incept & is_idle;
    assign send_acc   = req_ok & ~kill & ~incept & send & is_idle & fifo_room;
    assign stream_acc = req_ok & ~kill & ~incept & ~send & stream & is_idle & fifo_room;

    uarc_msg_fifo #(
        .WORD_MAG (WORD_MAG),
        .FIFO_MAG (FIFO_MAG)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .flush       (kill_acc),
        .push        (send_acc | stream_acc),
        .push_data   (data),
        .push_stream (stream_acc),
        .pop         (fifo_pop),
        .head_data   (head_data),
        .head_stream (head_stream),
        .empty       (fifo_empty),
        .full        (fifo_full)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // FSM next state; a kill aborts any incept in progress
    always_comb begin
        state_d = state_q;
        if (kill_acc) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE:        if (incept_acc)  state_d = INCEPT_WAIT;
                INCEPT_WAIT: if (incept_done) state_d = INCEPT_ACK;
                INCEPT_ACK:                   state_d = IDLE;
                default:                      state_d = IDLE;
            endcase
        end
    end

    // FSM outputs
    always_comb begin
        incept_req = (state_q == INCEPT_WAIT);
        incept_ack = (state_q == INCEPT_ACK) & reset & ~kill_acc;
    end

    // Incept payload is captured once at acceptance and held for the core.
    always_comb begin
        incept_perm_d = incept_perm_q;
        incept_addr_d = incept_addr_q;
        if (incept_acc) begin
            incept_perm_d = incept_permission;
            incept_addr_d = incept_address;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            incept_perm_q <= '0;
            incept_addr_q <= '0;
            kill_out_q    <= 1'b0;
        end else begin
            incept_perm_q <= incept_perm_d;
            incept_addr_q <= incept_addr_d;
            kill_out_q    <= kill_acc;
        end
    end

    assign kill_ack        = kill_acc;
    assign send_ack        = send_acc;
    assign stream_ack      = stream_acc;
    assign kill_out        = kill_out_q;
    assign incept_perm_out = incept_perm_q;
    assign incept_addr_out = incept_addr_q;

    // Head is blanked when empty so stale storage never reaches the consumer.
    assign msg_valid  = ~fifo_empty;
    assign msg_data   = fifo_empty ? '0 : head_data;
    assign msg_stream = ~fifo_empty & head_stream;

endmodule

// File: tb/tb_uarc_receiver.sv
// -----------------------------------------------------------------------------
// tb_uarc_receiver
// Directed bench for uarc_receiver (WORD_MAG=5, FIFO_MAG=2). Stimulus pushes
// the expected consumer words into a scoreboard queue; a monitor on the
// falling edge pops and compares whenever msg_valid & msg_ready. Handshake
// and control outputs are checked directly against hand-computed values.
// -----------------------------------------------------------------------------
module tb_uarc_receiver;

    localparam int WORD_MAG = 5;
    localparam int FIFO_MAG = 2;
    localparam int W        = 1 << WORD_MAG;

    typedef struct {
        logic [W-1:0] data;
        logic         stream;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         enable, kill, incept, send, stream;
    logic         kill_ack, incept_ack, send_ack, stream_ack;
    logic [W-1:0] data, self_permission, self_address;
    logic [W-1:0] incept_permission, incept_address;
`ifdef UARC_RECEIVER_ADDR_FILTER_EN
    logic [W-1:0] local_address;
`endif
    logic         msg_valid, msg_ready, msg_stream;
    logic [W-1:0] msg_data;
    logic         incept_req, incept_done, kill_out;
    logic [W-1:0] incept_perm_out, incept_addr_out;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb[$];

    uarc_receiver #(.WORD_MAG(WORD_MAG), .FIFO_MAG(FIFO_MAG)) dut (
        .clk               (clk),
        .reset             (reset),
        .enable            (enable),
        .kill              (kill),
        .incept            (incept),
        .send              (send),
        .stream            (stream),
        .kill_ack          (kill_ack),
        .incept_ack        (incept_ack),
        .send_ack          (send_ack),
        .stream_ack        (stream_ack),
        .data              (data),
        .self_permission   (self_permission),
        .self_address      (self_address),
        .incept_permission (incept_permission),
        .incept_address    (incept_address),
`ifdef UARC_RECEIVER_ADDR_FILTER_EN
        .local_address     (local_address),
`endif
        .msg_valid         (msg_valid),
        .msg_ready         (msg_ready),
        .msg_data          (msg_data),
        .msg_stream        (msg_stream),
        .incept_req        (incept_req),
        .incept_done       (incept_done),
        .incept_perm_out   (incept_perm_out),
        .incept_addr_out   (incept_addr_out),
        .kill_out          (kill_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Inputs change 1 ns after the rising edge; checks follow 1 ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // Scoreboard monitor: a transfer completes at the next rising edge.
    always @(negedge clk) begin
        if (reset && msg_valid && msg_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_msg", {31'd0, msg_stream, msg_data}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("msg_data", 64'(msg_data), 64'(e.data));
                check("msg_stream", 64'(msg_stream), 64'(e.stream));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; enable = 1'b0; kill = 1'b0; incept = 1'b0; send = 1'b0; stream = 1'b0;
        data = '0; self_permission = '0; self_address = '0;
        incept_permission = '0; incept_address = '0;
`ifdef UARC_RECEIVER_ADDR_FILTER_EN
        local_address = '0;
`endif
        msg_ready = 1'b0; incept_done = 1'b0;
        repeat (3) step();

        // Reset state
        check("rst_msg_valid", 64'(msg_valid), 0);
        check("rst_kill_out", 64'(kill_out), 0);
        check("rst_incept_req", 64'(incept_req), 0);
        check("rst_incept_perm", 64'(incept_perm_out), 0);
        check("rst_incept_addr", 64'(incept_addr_out), 0);
        check("rst_acks", 64'({kill_ack, incept_ack, send_ack, stream_ack}), 0);

        // Disabled requests are ignored
        reset = 1'b1; send = 1'b1; data = 32'h1234_5678;
        settle();
        check("disabled_send_ack", 64'(send_ack), 0);
        step();
        check("disabled_no_msg", 64'(msg_valid), 0);

        // Single send
        enable = 1'b1; data = 32'hDEAD_BEEF;
        settle();
        check("send_ack", 64'(send_ack), 1);
        sb.push_back('{data: 32'hDEAD_BEEF, stream: 1'b0});
        step();
        send = 1'b0;
        settle();
        check("send_valid", 64'(msg_valid), 1);
        check("send_data", 64'(msg_data), 64'hDEAD_BEEF);
        check("send_stream", 64'(msg_stream), 0);
        msg_ready = 1'b1;
        step();
        msg_ready = 1'b0;
        settle();
        check("send_drained", 64'(msg_valid), 0);

        // Stream backpressure: four words fit, the fifth waits for a pop
        stream = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            data = W'(i);
            settle();
            check("stream_ack", 64'(stream_ack), 1);
            sb.push_back('{data: W'(i), stream: 1'b1});
            step();
        end
        data = 32'd5;
        settle();
        check("full_stall", 64'(stream_ack), 0);
        step();
        check("full_stall_held", 64'(stream_ack), 0);
        msg_ready = 1'b1;
        settle();
        check("full_push_pop_ack", 64'(stream_ack), 1);
        sb.push_back('{data: 32'd5, stream: 1'b1});
        step();
        stream = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (!msg_valid) break;
            step();
        end
        check("stream_drained", 64'(msg_valid), 0);
        check("stream_sb_empty", 64'(sb.size()), 0);
        msg_ready = 1'b0;

        // Incept handshake; incept outranks a simultaneous send
        incept = 1'b1; send = 1'b1; data = 32'h77;
        incept_address = 32'h100; incept_permission = 32'hF00;
        settle();
        check("incept_over_send", 64'(send_ack), 0);
        step();
        incept = 1'b0;
        incept_address = 32'hABC; incept_permission = 32'h123;
        settle();
        check("incept_req", 64'(incept_req), 1);
        check("incept_addr_latched", 64'(incept_addr_out), 64'h100);
        check("incept_perm_latched", 64'(incept_perm_out), 64'hF00);
        check("no_send_in_wait", 64'(send_ack), 0);
        send = 1'b0;
        step();
        step();
        check("incept_wait_no_ack", 64'({incept_req, incept_ack}), 64'b10);
        incept_done = 1'b1;
        settle();
        check("incept_done_same_cycle", 64'(incept_ack), 0);
        step();
        incept_done = 1'b0;
        settle();
        check("incept_ack", 64'({incept_req, incept_ack}), 64'b01);
        step();
        check("incept_ack_one_cycle", 64'({incept_req, incept_ack}), 64'b00);
        check("incept_no_stray_msg", 64'(msg_valid), 0);

        // Kill outranks send and flushes queued words
        send = 1'b1;
        for (int i = 0; i < 3; i++) begin
            data = 32'hA0 + W'(i);
            step();
        end
        data = 32'h55; kill = 1'b1;
        settle();
        check("kill_ack", 64'(kill_ack), 1);
        check("kill_blocks_send", 64'(send_ack), 0);
        check("kill_queue_before", 64'(msg_valid), 1);
        step();
        kill = 1'b0; send = 1'b0;
        settle();
        check("kill_flushed", 64'(msg_valid), 0);
        check("kill_out_pulse", 64'(kill_out), 1);
        step();
        check("kill_out_single", 64'(kill_out), 0);

        // Kill in INCEPT_WAIT aborts without incept_ack
        incept = 1'b1;
        step();
        incept = 1'b0; kill = 1'b1;
        settle();
        check("kill_wait_ack", 64'(kill_ack), 1);
        step();
        kill = 1'b0;
        check("kill_wait_abort", 64'(incept_req), 0);
        step();
        check("kill_wait_no_ack", 64'(incept_ack), 0);

        // Reset during INCEPT_WAIT
        incept = 1'b1; incept_address = 32'h200;
        step();
        incept = 1'b0;
        check("rst_mid_req_before", 64'(incept_req), 1);
        reset = 1'b0;
        step();
        check("rst_mid_req_after", 64'(incept_req), 0);
        check("rst_mid_addr", 64'(incept_addr_out), 0);
        reset = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            check("rst_mid_no_ack", 64'({incept_ack, incept_req}), 0);
        end

`ifdef UARC_RECEIVER_ADDR_FILTER_EN
        // Address filter
        local_address = 32'h10; self_address = 32'h11; self_permission = 32'hFF;
        send = 1'b1; data = 32'hCAFE;
        settle();
        check("filter_reject", 64'(send_ack), 0);
        step();
        self_permission = 32'hF0;
        settle();
        check("filter_accept", 64'(send_ack), 1);
        sb.push_back('{data: 32'hCAFE, stream: 1'b0});
        step();
        send = 1'b0; msg_ready = 1'b1;
        step();
        msg_ready = 1'b0;
        check("filter_drained", 64'(msg_valid), 0);
`endif

        check("final_sb_empty", 64'(sb.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
